// File: rtl/morse_letter_sequencer_if.sv
// morse_letter_sequencer_if: head-of-queue letter handshake bus between the
// letter sequencer (master) and the character decoder (slave).
interface morse_letter_sequencer_if #(
  parameter int MAX_SYMS = 6
);
  logic [MAX_SYMS-1:0] letter_pattern;
  logic [2:0]          letter_len;
  logic                letter_space;
  logic                letter_valid;
  logic                letter_ready;

  modport master (
    output letter_pattern,
    output letter_len,
    output letter_space,
    output letter_valid,
    input  letter_ready
  );

  modport slave (
    input  letter_pattern,
    input  letter_len,
    input  letter_space,
    input  letter_valid,
    output letter_ready
  );
endinterface

// File: rtl/morse_letter_sequencer.sv
// morse_letter_sequencer: assembles dit/dah symbol codes into letter patterns,
// queues finished letters in a small FIFO and presents the head entry on a
// valid/ready bus. Flags overlong letters (err_long) and lost letters (err_ovf).
// Optional build macro SPACE_ENTRY_EN: a word space seen while idle pushes a
// standalone {pattern=0, len=0, space=1} entry so the decoder sees every break.
module morse_letter_sequencer #(
  parameter int MAX_SYMS = 6,
  parameter int FIFO_AW  = 2
) (
  input  logic                     bigclk,
  input  logic                     reset_n,
  input  logic [2:0]               ditsdahs,
  morse_letter_sequencer_if.master letter_bus,
  output logic [FIFO_AW:0]         fifo_count,
  output logic                     err_long,
  output logic                     err_ovf
);

  localparam int                 DEPTH      = 1 << FIFO_AW;
  localparam logic [2:0]         LEN_MAX_C  = 3'(MAX_SYMS);
  localparam logic [FIFO_AW:0]   CNT_FULL_C = (FIFO_AW+1)'(DEPTH);
`ifdef SPACE_ENTRY_EN
  localparam logic               SPACE_ENTRY_C = 1'b1;
`else
  localparam logic               SPACE_ENTRY_C = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_TOO_LONG = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [2:0]          prev_code_r;
  logic                sym_s;
  logic                dah_s;
  logic                gap_s;
  logic                space_s;

  logic [MAX_SYMS-1:0] shift_r;
  logic [2:0]          len_r;

  logic                start_s;
  logic                append_s;
  logic                clear_s;
  logic                long_set_s;
  logic                push_req_s;
  logic [MAX_SYMS-1:0] push_pat_s;
  logic [2:0]          push_len_s;
  logic                push_spc_s;

  logic [MAX_SYMS-1:0] pat_mem_r [DEPTH];
  logic [2:0]          len_mem_r [DEPTH];
  logic                spc_mem_r [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr_r;
  logic [FIFO_AW-1:0]  rd_ptr_r;
  logic [FIFO_AW:0]    count_r;
  logic                full_s;
  logic                pop_s;
  logic                push_ok_s;
  logic                drop_s;
  logic                err_long_r;
  logic                err_ovf_r;

  // Decode the incoming code; a word space only counts on the first cycle of its run.
  always_comb begin
    sym_s   = (ditsdahs == 3'd1) || (ditsdahs == 3'd2);
    dah_s   = (ditsdahs == 3'd2);
    gap_s   = (ditsdahs == 3'd3);
    space_s = (ditsdahs == 3'd4) && (prev_code_r != 3'd4);
  end

  // Remember last cycle's code to detect the start of a word-space run.
  always_ff @(posedge bigclk or negedge reset_n) begin
    if (!reset_n) begin
      prev_code_r <= 3'd0;
    end else begin
      prev_code_r <= ditsdahs;
    end
  end

  // Assembler state register.
  always_ff @(posedge bigclk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Assembler next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (sym_s) begin
          state_nxt_s = ST_COLLECT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (sym_s && (len_r == LEN_MAX_C)) begin
          state_nxt_s = ST_TOO_LONG;
        end else if (gap_s || space_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_COLLECT;
        end
      end
      ST_TOO_LONG: begin
        if (gap_s || space_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_TOO_LONG;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Assembler actions: shift-register control, letter commit and overlong flag.
  always_comb begin
    start_s    = 1'b0;
    append_s   = 1'b0;
    clear_s    = 1'b0;
    long_set_s = 1'b0;
    push_req_s = 1'b0;
    push_pat_s = {MAX_SYMS{1'b0}};
    push_len_s = 3'd0;
    push_spc_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sym_s) begin
          start_s = 1'b1;
        end else if (space_s) begin
          push_req_s = SPACE_ENTRY_C;
          push_spc_s = SPACE_ENTRY_C;
        end else begin
          start_s = 1'b0;
        end
      end
      ST_COLLECT: begin
        if (sym_s) begin
          if (len_r == LEN_MAX_C) begin
            clear_s = 1'b1;
          end else begin
            append_s = 1'b1;
          end
        end else if (gap_s || space_s) begin
          push_req_s = 1'b1;
          push_pat_s = shift_r;
          push_len_s = len_r;
          push_spc_s = space_s;
          clear_s    = 1'b1;
        end else begin
          clear_s = 1'b0;
        end
      end
      ST_TOO_LONG: begin
        if (gap_s || space_s) begin
          long_set_s = 1'b1;
        end else begin
          long_set_s = 1'b0;
        end
      end
      default: begin
        clear_s = 1'b1;
      end
    endcase
  end

  // Letter shift register: first symbol lands in bit 0, dah = 1.
  always_ff @(posedge bigclk or negedge reset_n) begin
    if (!reset_n) begin
      shift_r <= {MAX_SYMS{1'b0}};
      len_r   <= 3'd0;
    end else if (start_s) begin
      shift_r <= (MAX_SYMS)'(dah_s);
      len_r   <= 3'd1;
    end else if (append_s) begin
      shift_r <= shift_r | ((MAX_SYMS)'(dah_s) << len_r);
      len_r   <= len_r + 3'd1;
    end else if (clear_s) begin
      shift_r <= {MAX_SYMS{1'b0}};
      len_r   <= 3'd0;
    end else begin
      shift_r <= shift_r;
      len_r   <= len_r;
    end
  end

  // FIFO push/pop qualification; a full FIFO still accepts when it pops the same cycle.
  always_comb begin
    full_s    = (count_r == CNT_FULL_C);
    pop_s     = (count_r != {(FIFO_AW+1){1'b0}}) && letter_bus.letter_ready;
    push_ok_s = push_req_s && (!full_s || pop_s);
    drop_s    = push_req_s && full_s && !pop_s;
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge bigclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pat_mem_r[i] <= {MAX_SYMS{1'b0}};
        len_mem_r[i] <= 3'd0;
        spc_mem_r[i] <= 1'b0;
      end
      wr_ptr_r <= {FIFO_AW{1'b0}};
      rd_ptr_r <= {FIFO_AW{1'b0}};
      count_r  <= {(FIFO_AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        pat_mem_r[wr_ptr_r] <= push_pat_s;
        len_mem_r[wr_ptr_r] <= push_len_s;
        spc_mem_r[wr_ptr_r] <= push_spc_s;
        wr_ptr_r            <= wr_ptr_r + {{(FIFO_AW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(FIFO_AW-1){1'b0}}, 1'b1};
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + {{FIFO_AW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{FIFO_AW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge bigclk or negedge reset_n) begin
    if (!reset_n) begin
      err_long_r <= 1'b0;
      err_ovf_r  <= 1'b0;
    end else begin
      err_long_r <= err_long_r | long_set_s;
      err_ovf_r  <= err_ovf_r | drop_s;
    end
  end

  assign letter_bus.letter_pattern = pat_mem_r[rd_ptr_r];
  assign letter_bus.letter_len     = len_mem_r[rd_ptr_r];
  assign letter_bus.letter_space   = spc_mem_r[rd_ptr_r];
  assign letter_bus.letter_valid   = (count_r != {(FIFO_AW+1){1'b0}});
  assign fifo_count                = count_r;
  assign err_long                  = err_long_r;
  assign err_ovf                   = err_ovf_r;

endmodule

// File: doc/morse_letter_sequencer.md
Name: morse_letter_sequencer

Overview:
- Sits between the dit/dah detector and the character decoder.
- Consumes the 3-bit per-cycle symbol code stream: 0 none, 1 dit, 2 dah, 3 letter gap, 4 word space.
- Assembles dits and dahs into complete letter patterns.
- Queues finished letters in a small FIFO and hands them downstream with a valid/ready handshake.
- Flags overlong letters and queue overflow.

Parameters:
- MAX_SYMS, 6: maximum symbols per letter; legal range 1..7.
- FIFO_AW, 2: FIFO address width; depth is 2**FIFO_AW entries.

Ports:
- bigclk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ditsdahs  in  3  symbol code from the detector. It is sampled every cycle. Code 4 may persist for many cycles.
- letter_pattern  out  MAX_SYMS  head entry pattern. Bit i is symbol i (1 = dah, 0 = dit); the first received symbol is bit 0. Unused bits are 0.
- letter_len  out  3  head entry symbol count, 0..MAX_SYMS.
- letter_space  out  1  head entry is followed by a word space.
- letter_valid  out  1  head entry is present (FIFO count > 0).
- letter_ready  in  1  downstream accepts the head entry.
- fifo_count  out  FIFO_AW+1  number of queued entries.
- err_long  out  1  sticky: a letter exceeded MAX_SYMS symbols and was dropped.
- err_ovf  out  1  sticky: a completed letter was lost because the FIFO was full.

Behaviour:
- Reset (asynchronous, while reset_n=0):
  - Assembler returns to IDLE; shift register and length are cleared.
  - prev_code register is cleared to 0.
  - FIFO pointers and count are cleared.
  - All outputs are 0: letter_valid=0, fifo_count=0, err_long=0, err_ovf=0.
  - A partial letter or any queued entries present when reset asserts are discarded.
- Code qualification:
  - Codes 1, 2 and 3 act on every cycle they are present.
  - Code 4 acts only on the first cycle of a run (prev_code != 4).
  - Codes 0, 5, 6 and 7 are ignored.
- Assembler FSM: IDLE, COLLECT, TOO_LONG.
  - IDLE, dit/dah: store the symbol at bit 0, len=1, go to COLLECT.
  - IDLE, gap or space: no action.
  - COLLECT, dit/dah with len<MAX_SYMS: store the symbol at bit len, len+1.
  - COLLECT, dit/dah with len==MAX_SYMS: discard the partial letter, go to TOO_LONG.
  - COLLECT, gap: commit {pattern, len, space=0}, go to IDLE.
  - COLLECT, space: commit {pattern, len, space=1}, go to IDLE.
  - TOO_LONG, dit/dah: no action.
  - TOO_LONG, gap or space: set err_long, commit nothing, go to IDLE.
  - A gap and the first dit/dah of the next letter always arrive in separate cycles, so no merge case exists.
- FIFO:
  - Commit pushes at the same edge the terminating code is sampled.
  - The entry is visible at the head (letter_valid=1) in the cycle after that edge; latency is 1 cycle.
  - Pop occurs when letter_valid && letter_ready at a rising edge. The head outputs update to the next entry after that edge.
  - Full and commit without pop: the entry is dropped, err_ovf is set, and the FIFO is unchanged.
  - Full and commit with pop in the same cycle: both happen; count is unchanged.
  - Empty and commit: head outputs valid next cycle. There is no same-cycle bypass.
  - Pointers wrap modulo the depth.
  - letter_ready while letter_valid=0 has no effect.
- Head outputs are driven from registered storage. letter_pattern, letter_len and letter_space are don't-care while letter_valid=0.
- err_long and err_ovf clear only on reset.

Optional Feature:
- Macro: SPACE_ENTRY_EN.
- Defined: the first cycle of code 4 while in IDLE pushes a standalone entry {pattern=0, len=0, space=1}. The push obeys the normal full/overflow rules. This entry lets the decoder see word breaks that are not preceded by a letter, for example after a dropped overlong letter.
- Not defined: code 4 in IDLE is ignored, and len=0 entries never appear.

Test Plan:
- Sequence: reset; then 1,0,2,0,1,0,3 (R) with letter_ready=1. Required: one entry, pattern=0b0000_10 (bits 0..2 = 0,1,0), len=3, space=0, letter_valid high for exactly 1 cycle.
- Sequence: codes 2,2,2 (O); then code 4 held for 10 cycles; letter_ready=0. Required: exactly one entry, pattern=0b111, len=3, space=1; fifo_count=1.
- Sequence: 7 dits then gap, MAX_SYMS=6. Required: no entry pushed; err_long=1; the next letter 1,3 yields pattern=0, len=1.
- Sequence: letter_ready=0; push 5 single-dit letters into a depth-4 FIFO. Required: fifo_count=4, err_ovf=1. Then raise letter_ready; required: 4 entries drain in order.
- Sequence: FIFO full with letter_ready=1 and a commit in the same cycle. Required: fifo_count stays 4, err_ovf stays 0, order preserved.
- Sequence: reset_n pulsed low mid-letter (after 1,2) with 2 entries queued. Required: immediately fifo_count=0, letter_valid=0, errors 0. Then 1,3 yields len=1, pattern=0.
